// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared definitions for the binary fully-connected engine:
//               FSM state encoding, accumulator saturation limits and an
//               adder-tree popcount over a fixed 256-bit window.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Widest activation vector the popcount helper accepts.
    localparam int c_POP_MAX_BITS = 256;

    // Largest value a w-bit two's-complement accumulator can hold.
    function automatic longint sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value a w-bit two's-complement accumulator can hold.
    function automatic longint sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Pairwise reduction: each pass halves the number of partial sums, so
    // the logic elaborates as a balanced adder tree rather than a chain.
    // Callers zero-extend narrower vectors; padding bits contribute nothing.
    function automatic logic [8:0] popcount(input logic [c_POP_MAX_BITS-1:0] v);
        logic [8:0] s [c_POP_MAX_BITS];
        for (int i = 0; i < c_POP_MAX_BITS; i++) begin
            s[i] = {8'd0, v[i]};
        end
        for (int w = c_POP_MAX_BITS / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                s[i] = s[2*i] + s[2*i+1];
            end
        end
        return s[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_xnor_popcnt.sv
`default_nettype none
// ============================================================================
// Module      : bnn_xnor_popcnt
// Description : One neuron's per-beat contribution for a binary dot product.
//               Activations and weights encode +1 as 1 and -1 as 0, so the
//               signed product sum is 2*popcount(xnor) - IN_BITS.
// Ports       : act [IN_BITS]  binary activations
//               w   [IN_BITS]  binary weights of this neuron
//               c   [C_W]      signed contribution, -IN_BITS..+IN_BITS
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_popcnt
    import bnn_pkg::*;
#(
    parameter int IN_BITS = 32,
    parameter int C_W     = $clog2(IN_BITS) + 2
) (
    input  logic [IN_BITS-1:0]    act,
    input  logic [IN_BITS-1:0]    w,
    output logic signed [C_W-1:0] c
);

    logic [IN_BITS-1:0] w_match;
    logic [8:0]         w_pop;

    assign w_match = ~(act ^ w);
    assign w_pop   = popcount(c_POP_MAX_BITS'(w_match));

    // The intermediate 2*pop may not fit C_W as a signed value, but the
    // difference always does, so modular arithmetic gives the right result.
    assign c = signed'(C_W'({w_pop, 1'b0}) - C_W'(IN_BITS));

endmodule
`default_nettype wire

// File: rtl/bnn_fc_engine.sv
`default_nettype none
// ============================================================================
// Module      : bnn_fc_engine
// Description : Binary fully-connected layer engine. Streams activation and
//               weight beats, accumulates a saturating signed dot product for
//               NEURONS neurons in parallel, and presents the sums and their
//               binarised signs with a valid/ready handshake.
// Ports       : clk, rst (synchronous, active-low)
//               cfg_beats          beats per vector, latched on first beat
//               in_valid/in_ready  beat handshake
//               in_act, in_w       activations and per-neuron weights
//               thr                per-neuron signed threshold (optional)
//               out_valid/out_ready result handshake
//               out_sum, out_sign  per-neuron sums and sign bits
// Options     : BNN_FC_THRESH_EN - adds the thr port; otherwise thresholds
//               are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_fc_engine
    import bnn_pkg::*;
#(
    parameter int IN_BITS = 32,
    parameter int NEURONS = 8,
    parameter int ACC_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                cfg_beats,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_BITS-1:0]         in_act,
    input  logic [NEURONS*IN_BITS-1:0] in_w,
`ifdef BNN_FC_THRESH_EN
    input  logic [NEURONS*ACC_W-1:0]   thr,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURONS*ACC_W-1:0]   out_sum,
    output logic [NEURONS-1:0]         out_sign
);

    localparam int c_C_W   = $clog2(IN_BITS) + 2;
    // One bit wider than either operand so acc + c can never wrap before
    // it is clamped.
    localparam int c_SUM_W = ((ACC_W > c_C_W) ? ACC_W : c_C_W) + 1;
    localparam logic signed [c_SUM_W-1:0] c_SUM_HI = c_SUM_W'(sat_hi(ACC_W));
    localparam logic signed [c_SUM_W-1:0] c_SUM_LO = c_SUM_W'(sat_lo(ACC_W));

    state_t                  r_state;
    logic [15:0]             r_beats;
    logic [15:0]             r_cnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [NEURONS-1:0]      r_sign;
    logic signed [ACC_W-1:0] r_acc [NEURONS];

    logic signed [ACC_W-1:0] w_sat [NEURONS];
    logic [NEURONS-1:0]      w_sign;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic [15:0]             w_cfg_beats;

    assign w_accept    = in_valid && r_in_ready;
    assign w_first     = (r_state == IDLE);
    assign w_cfg_beats = (cfg_beats == 16'd0) ? 16'd1 : cfg_beats;
    assign w_last      = w_first ? (w_cfg_beats == 16'd1)
                                 : (r_cnt + 16'd1 == r_beats);

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        logic signed [c_C_W-1:0]   w_c;
        logic signed [ACC_W-1:0]   w_base;
        logic signed [ACC_W-1:0]   w_thr;
        logic signed [c_SUM_W-1:0] w_sum;

        bnn_xnor_popcnt #(
            .IN_BITS (IN_BITS),
            .C_W     (c_C_W)
        ) u_xnor_popcnt (
            .act (in_act),
            .w   (in_w[n*IN_BITS +: IN_BITS]),
            .c   (w_c)
        );

        // The first beat of a vector loads rather than accumulates, and is
        // clamped too in case a single beat already exceeds ACC_W.
        assign w_base = w_first ? '0 : r_acc[n];
        assign w_sum  = {{(c_SUM_W-ACC_W){w_base[ACC_W-1]}}, w_base}
                      + {{(c_SUM_W-c_C_W){w_c[c_C_W-1]}}, w_c};
        assign w_sat[n] = (w_sum > c_SUM_HI) ? ACC_W'(c_SUM_HI) :
                          (w_sum < c_SUM_LO) ? ACC_W'(c_SUM_LO) :
                                               w_sum[ACC_W-1:0];

`ifdef BNN_FC_THRESH_EN
        assign w_thr = thr[n*ACC_W +: ACC_W];
`else
        assign w_thr = '0;
`endif
        assign w_sign[n] = (w_sat[n] >= w_thr);

        // The accumulator is frozen in HOLD, so it doubles as the result.
        assign out_sum[n*ACC_W +: ACC_W] = r_acc[n];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_beats     <= 16'd0;
            r_cnt       <= 16'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sign      <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_state == HOLD) begin
            if (out_ready) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
            end
        end else begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
                for (int i = 0; i < NEURONS; i++) begin
                    r_acc[i] <= w_sat[i];
                end
                r_cnt <= w_first ? 16'd1 : r_cnt + 16'd1;
                if (w_first) begin
                    r_beats <= w_cfg_beats;
                end
                if (w_last) begin
                    r_state     <= HOLD;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_sign      <= w_sign;
                end else begin
                    r_state <= ACC;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sign  = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_bnn_fc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_fc_engine
// Description : Self-checking bench for bnn_fc_engine (IN_BITS=8, NEURONS=2,
//               ACC_W=8). Expected sums come from a plain arithmetic model of
//               the binary dot product with clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_fc_engine;

    localparam int IN_BITS = 8;
    localparam int NEURONS = 2;
    localparam int ACC_W   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cfg_beats = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_act = 8'd0;
    logic [15:0] in_w = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [1:0]  out_sign;
`ifdef BNN_FC_THRESH_EN
    logic [15:0] thr = 16'd0;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]  v_act [64];
    logic [15:0] v_w   [64];
    int          exp_sum [NEURONS];
    logic [1:0]  exp_sign;

    bnn_fc_engine #(
        .IN_BITS (IN_BITS),
        .NEURONS (NEURONS),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_beats (cfg_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_w      (in_w),
`ifdef BNN_FC_THRESH_EN
        .thr       (thr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sign  (out_sign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Reference: each beat adds (+1 per agreeing bit, -1 per disagreeing bit),
    // the running total is clamped to the ACC_W range after every beat.
    function automatic void model(input int nb);
        int         acc;
        int         c;
        int         t;
        logic [7:0] m;
        for (int n = 0; n < NEURONS; n++) begin
            acc = 0;
            for (int b = 0; b < nb; b++) begin
                m   = ~(v_act[b] ^ v_w[b][n*8 +: 8]);
                c   = $countones(m) - (8 - $countones(m));
                acc = acc + c;
                if (acc > 127)  acc = 127;
                if (acc < -128) acc = -128;
            end
`ifdef BNN_FC_THRESH_EN
            t = int'($signed(thr[n*8 +: 8]));
`else
            t = 0;
`endif
            exp_sum[n]  = acc;
            exp_sign[n] = (acc >= t);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name);
        int got;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s out_valid: got %b, required 1", name, out_valid);
        end
        for (int n = 0; n < NEURONS; n++) begin
            got = int'($signed(out_sum[n*8 +: 8]));
            tests++;
            if (got != exp_sum[n]) begin
                fails++;
                $display("FAIL %s sum%0d: got %0d, required %0d", name, n, got, exp_sum[n]);
            end
        end
        tests++;
        if (out_sign !== exp_sign) begin
            fails++;
            $display("FAIL %s out_sign: got %b, required %b", name, out_sign, exp_sign);
        end
    endtask

    // Sends up to stop_after beats of the vector in v_act/v_w with random idle
    // gaps; cfg_beats is scrambled on every beat after the first.
    task automatic run_vector(input int cfg, input int stop_after, input int gap_max,
                              input string name);
        int nb;
        int gaps;
        bit ok;
        nb = (cfg == 0) ? 1 : cfg;
        model(nb);
        for (int b = 0; b < nb && b < stop_after; b++) begin
            in_valid = 1'b0;
            gaps = int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gaps; g++) tick();
            in_valid  = 1'b1;
            in_act    = v_act[b];
            in_w      = v_w[b];
            cfg_beats = (b == 0) ? 16'(cfg) : 16'($urandom);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                ok = in_ready;
                tick();
            end
            in_valid = 1'b0;
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s accept beat %0d: in_ready stayed 0, required 1", name, b);
                return;
            end
            if (b < nb - 1) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s early_valid beat %0d: got %b, required 0", name, b, out_valid);
                end
            end else begin
                check_result(name);
            end
        end
    endtask

    task automatic consume(input string name);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s hold_in_ready: got %b, required 0", name, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s release_valid: got %b, required 0", name, out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_after_release: got %b, required 1", name, in_ready);
        end
    endtask

    task automatic apply_reset_checks(input string name);
        rst = 1'b0;
        in_valid = 1'($urandom);
        tick();
        tick();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'd0 || out_sign !== 2'b00) begin
            fails++;
            $display("FAIL %s in_reset: ready=%b valid=%b sum=%h sign=%b, required 0 0 0000 00",
                     name, in_ready, out_valid, out_sum, out_sign);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_after_reset: got %b, required 1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset_checks("reset");
    endtask

    task automatic test_single_beat();
        int got;
        v_act[0] = 8'hFF;
        v_w[0]   = {8'h00, 8'hFF};
        run_vector(1, 1, 0, "single");
        got = int'($signed(out_sum[7:0]));
        tests++;
        if (got != 8 || out_sign !== 2'b01) begin
            fails++;
            $display("FAIL single_const: sum0=%0d sign=%b, required 8 01", got, out_sign);
        end
        consume("single");
    endtask

    task automatic test_gaps();
        int got;
        for (int b = 0; b < 3; b++) v_act[b] = 8'hFF;
        v_w[0] = {8'($urandom), 8'hFF};
        v_w[1] = {8'($urandom), 8'h00};
        v_w[2] = {8'($urandom), 8'h1F};
        run_vector(3, 3, 3, "gaps");
        got = int'($signed(out_sum[7:0]));
        tests++;
        if (got != 2) begin
            fails++;
            $display("FAIL gaps_const: sum0=%0d, required 2", got);
        end
        consume("gaps");
    endtask

    task automatic test_saturate();
        int got;
        for (int b = 0; b < 20; b++) begin
            v_act[b] = 8'($urandom);
            v_w[b]   = {8'($urandom), v_act[b]};
        end
        run_vector(20, 20, 0, "sat_pos");
        got = int'($signed(out_sum[7:0]));
        tests++;
        if (got != 127) begin
            fails++;
            $display("FAIL sat_pos_const: sum0=%0d, required 127", got);
        end
        consume("sat_pos");
        for (int b = 0; b < 20; b++) begin
            v_act[b] = 8'($urandom);
            v_w[b]   = {8'($urandom), ~v_act[b]};
        end
        run_vector(20, 20, 1, "sat_neg");
        got = int'($signed(out_sum[7:0]));
        tests++;
        if (got != -128) begin
            fails++;
            $display("FAIL sat_neg_const: sum0=%0d, required -128", got);
        end
        consume("sat_neg");
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 2; b++) begin
            v_act[b] = 8'($urandom);
            v_w[b]   = 16'($urandom);
        end
        run_vector(2, 2, 1, "bp");
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_act   = 8'($urandom);
            in_w     = 16'($urandom);
            tick();
            check_result("bp_stall");
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall in_ready cycle %0d: got %b, required 0", k, in_ready);
            end
        end
        in_valid = 1'b0;
        consume("bp");
        for (int b = 0; b < 3; b++) begin
            v_act[b] = 8'($urandom);
            v_w[b]   = 16'($urandom);
        end
        run_vector(3, 3, 1, "bp_next");
        consume("bp_next");
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 4; b++) begin
            v_act[b] = 8'($urandom);
            v_w[b]   = 16'($urandom);
        end
        run_vector(4, 2, 1, "mid");
        apply_reset_checks("mid_reset");
        v_act[0] = 8'($urandom);
        v_w[0]   = 16'($urandom);
        run_vector(1, 1, 0, "mid_fresh");
        consume("mid_fresh");
    endtask

    task automatic test_random();
        int cfg;
        for (int v = 0; v < 12; v++) begin
            cfg = int'($urandom_range(6, 0));
            for (int b = 0; b < 6; b++) begin
                v_act[b] = 8'($urandom);
                v_w[b]   = 16'($urandom);
            end
            run_vector(cfg, 64, 2, "random");
            consume("random");
        end
    endtask

`ifdef BNN_FC_THRESH_EN
    task automatic test_thresh();
        for (int b = 0; b < 3; b++) v_act[b] = 8'hFF;
        v_w[0] = {8'($urandom), 8'hFF};
        v_w[1] = {8'($urandom), 8'h00};
        v_w[2] = {8'($urandom), 8'h1F};
        thr = {8'($urandom), 8'sd4};
        run_vector(3, 3, 1, "thr4");
        tests++;
        if (out_sign[0] !== 1'b0) begin
            fails++;
            $display("FAIL thr4_sign0: got %b, required 0", out_sign[0]);
        end
        consume("thr4");
        thr = {8'($urandom), 8'sd2};
        run_vector(3, 3, 1, "thr2");
        tests++;
        if (out_sign[0] !== 1'b1) begin
            fails++;
            $display("FAIL thr2_sign0: got %b, required 1", out_sign[0]);
        end
        consume("thr2");
        thr = 16'd0;
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_single_beat();
        test_gaps();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef BNN_FC_THRESH_EN
        test_thresh();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
